nand_uart_sequencer: RTL and testbench
======================================

// Module: nand_uart_sequencer
// PURPOSE
//  Command sequencer between the simpleuart register interface and nand_master.
//  Parses framed host commands from UART, drives cmd_in/activate/data_in, and waits on busy with a timeout.
//  Returns ack/status/read bytes over UART. Replaces ad-hoc per-character handling in top.
// PARAMETERS
//  TIMEOUT_CYC  24'd1_200_000  max hw_clk cycles busy may stay high before abort (100 ms @12 MHz)
//  START_WIN    8'd8           cycles after activate to see busy rise; none -> op treated as done
//  READ_CMD     8'h0A          nand_master cmd_in code that fetches one byte into data_out
// PORTS
//  hw_clk        in   1   clock
//  resetn        in   1   reset, synchronous, active-low
//  reg_dat_do    in   32  UART rx data; 32'hFFFF_FFFF = no byte
//  reg_dat_wait  in   1   UART tx busy; write accepted in a cycle with we=1 & wait=0
//  reg_dat_re    out  1   one-cycle pulse: consume current rx byte
//  reg_dat_we    out  1   tx write request, held until accepted
//  reg_dat_di    out  32  tx byte, zero-extended
//  cmd_in        out  8   nand_master command code
//  nand_activate out  1   one-cycle start pulse to nand_master
//  nand_data_in  out  8   byte for nand_master writes
//  nand_busy     in   1   nand_master busy
//  nand_data_out in   8   nand_master result byte
//  seq_idle      out  1   1 when in IDLE (LED/debug)
// BEHAVIOUR
//  Reset: all outputs 0 except seq_idle=1; state IDLE; timeout flag 0; in-flight frame discarded.
//  Rx: byte valid when reg_dat_do!=~0. FSM latches do[7:0] and pulses re the same cycle.
//   Byte not consumed while FSM is busy; it stays queued in the UART.
//  Opcodes:
//   'C'(43h) x  cmd_in<=x, issue, wait; reply 'K' or 'T'
//   'W'(57h) x  nand_data_in<=x; reply 'K'
//   'R'(52h) n  n x (cmd_in<=READ_CMD, issue, wait, send nand_data_out); n=0 means 256; 'T' aborts loop
//   'S'(53h)    reply {6'b0, tmo_flag, nand_busy}; then clears tmo_flag
//   other       reply '?'(3Fh)
//  States: IDLE -> GET_ARG (C/W/R) -> ISSUE -> WAIT_START -> WAIT_DONE -> SEND -> TX_WAIT -> IDLE | ISSUE (R loop).
//  ISSUE: activate=1 exactly one cycle; cmd_in is stable one cycle before and throughout the op.
//  WAIT_START: exit on busy=1 or after START_WIN cycles.
//  WAIT_DONE: exit on busy=0. Counter at TIMEOUT_CYC -> set tmo_flag, reply 'T', back to IDLE; NAND is not reset.
//  Busy already high at ISSUE: the op still issues; WAIT_START exits immediately.
//  TX: we=1 with di set; deassert the cycle after we&!wait; never two writes back-to-back without we=0 for one cycle.
//  Counters: R remaining count is 9-bit (256 load), decrements after each SEND; timeout counter is 24-bit, saturating.
//  Reset mid-op: activate/we drop the next edge; no partial reply is guaranteed.
// CONFIGURATION
//  NAND_SEQ_ECHO_EN defined:
//   Every consumed rx byte (opcode and argument) is echoed via TX before further processing; adds one TX transaction per byte.
//  NAND_SEQ_ECHO_EN undefined:
//   No echo; only replies listed above.
// TESTING
//  1. reset, rx 'W',0xA5 -> nand_data_in=A5h, tx 'K'; activate never pulses
//  2. rx 'C',0x90; model busy high 3 cyc after activate for 50 cyc
//     -> single activate pulse, cmd_in=90h, tx 'K' after busy falls
//  3. rx 'R',0x03; model data_out=11h,22h,33h
//     -> 3 activate pulses with cmd_in=0Ah, tx 11h,22h,33h in order
//  4. TIMEOUT_CYC=100, rx 'C',0x60, busy stuck high -> tx 'T' at cycle 100
//     then rx 'S' -> tx 03h; rx 'S' again with busy low -> tx 00h
//  5. rx 'X' -> tx '?'; hold reg_dat_wait=1 for 500 cyc -> we held, di stable, one write only
//  6. resetn low during WAIT_DONE -> next edge: activate=0, we=0, seq_idle=1; 'S' reply then 00h/01h per busy

Source files
------------

// File: rtl/nand_uart_sequencer_if.sv
// Bus bundle between the sequencer, the simpleuart register port and nand_master.
// The master modport is the sequencer side. The slave modport is the UART/NAND side.
interface nand_uart_sequencer_if;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        reg_dat_re;
  logic        reg_dat_we;
  logic [31:0] reg_dat_di;
  logic [7:0]  cmd_in;
  logic        nand_activate;
  logic [7:0]  nand_data_in;
  logic        nand_busy;
  logic [7:0]  nand_data_out;

  modport master (
    input  reg_dat_do, reg_dat_wait, nand_busy, nand_data_out,
    output reg_dat_re, reg_dat_we, reg_dat_di, cmd_in, nand_activate, nand_data_in
  );

  modport slave (
    output reg_dat_do, reg_dat_wait, nand_busy, nand_data_out,
    input  reg_dat_re, reg_dat_we, reg_dat_di, cmd_in, nand_activate, nand_data_in
  );
endinterface

// File: rtl/nand_uart_sequencer.sv
// nand_uart_sequencer: parses framed host commands from the UART and drives nand_master.
// Each command returns a single-byte reply over the UART:
//   'C' x  issue NAND command x                  -> 'K' on completion, 'T' on timeout
//   'W' x  load nand_data_in                      -> 'K'
//   'R' n  n one-byte reads (n = 0 means 256)     -> the read bytes; a timeout sends 'T' and ends the loop
//   'S'    status {6'b0, tmo_flag, busy}           -> then tmo_flag is cleared
//   other                                          -> '?'
// Optional build macro NAND_SEQ_ECHO_EN: echo every consumed rx byte before processing it.
//
// state        | meaning
// S_IDLE       | waiting for an opcode byte
// S_GET_ARG    | waiting for the argument byte of C/W/R
// S_ISSUE      | first cycle: cmd_in setup; second cycle: activate pulse
// S_WAIT_START | waiting up to START_WIN cycles for busy to rise
// S_WAIT_DONE  | waiting for busy to fall; timeout down-counter running
// S_SEND       | tx write held until the UART accepts it
// S_TX_WAIT    | one idle cycle with we=0; then loop the next read or return to idle
// S_ECHO       | echo build only: tx write of the consumed rx byte
// S_ECHO_GAP   | echo build only: we=0 gap, then process the echoed byte
module nand_uart_sequencer #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_200_000,
  parameter logic [7:0]  START_WIN   = 8'd8,
  parameter logic [7:0]  READ_CMD    = 8'h0A
) (
  input  logic                          hw_clk,
  input  logic                          resetn,
  nand_uart_sequencer_if.master         bus,
  output logic                          seq_idle
);

  localparam logic [7:0] OP_C  = 8'h43;
  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] OP_S  = 8'h53;
  localparam logic [7:0] RPL_K = 8'h4B;
  localparam logic [7:0] RPL_T = 8'h54;
  localparam logic [7:0] RPL_Q = 8'h3F;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_ARG, S_ISSUE, S_WAIT_START, S_WAIT_DONE,
    S_SEND, S_TX_WAIT, S_ECHO, S_ECHO_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  ndata_q, ndata_d;
  logic [7:0]  tx_q, tx_d;
  logic        tmo_q, tmo_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  win_q, win_d;
  logic [23:0] tmr_q, tmr_d;
  logic        arm_q, arm_d;

  logic        rx_take;
  logic        re;
  logic        act;
  logic        done;
  logic        proc_go;
  logic        proc_arg;
  logic [7:0]  proc_byte;

  // Rx bytes are not taken while the synchronous reset is asserted.
  assign rx_take = (bus.reg_dat_do != 32'hFFFF_FFFF) && resetn;

`ifdef NAND_SEQ_ECHO_EN
  logic [7:0] echo_q, echo_d;
  logic       argph_q, argph_d;

  assign proc_go   = (state_q == S_ECHO_GAP);
  assign proc_byte = echo_q;
  assign proc_arg  = argph_q;

  // Holds the echoed byte and its position in the frame until the echo has been sent.
  always_ff @(posedge hw_clk) begin
    if (!resetn) begin
      echo_q  <= 8'h00;
      argph_q <= 1'b0;
    end else begin
      echo_q  <= echo_d;
      argph_q <= argph_d;
    end
  end
`else
  assign proc_go   = ((state_q == S_IDLE) || (state_q == S_GET_ARG)) && rx_take;
  assign proc_byte = bus.reg_dat_do[7:0];
  assign proc_arg  = (state_q == S_GET_ARG);
`endif

  // State and datapath registers.
  always_ff @(posedge hw_clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= 8'h00;
      cmd_q   <= 8'h00;
      ndata_q <= 8'h00;
      tx_q    <= 8'h00;
      tmo_q   <= 1'b0;
      cnt_q   <= 9'd0;
      win_q   <= 8'd0;
      tmr_q   <= 24'd0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cmd_q   <= cmd_d;
      ndata_q <= ndata_d;
      tx_q    <= tx_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      tmr_q   <= tmr_d;
      arm_q   <= arm_d;
    end
  end

  // Next-state logic, rx consume pulse, activate pulse, and command dispatch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cmd_d   = cmd_q;
    ndata_d = ndata_q;
    tx_d    = tx_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    tmr_d   = tmr_q;
    arm_d   = arm_q;
    re      = 1'b0;
    act     = 1'b0;
    done    = 1'b0;
`ifdef NAND_SEQ_ECHO_EN
    echo_d  = echo_q;
    argph_d = argph_q;
`endif

    case (state_q)
      S_IDLE, S_GET_ARG: begin
        if (rx_take) begin
          re = 1'b1;
`ifdef NAND_SEQ_ECHO_EN
          echo_d  = bus.reg_dat_do[7:0];
          tx_d    = bus.reg_dat_do[7:0];
          argph_d = (state_q == S_GET_ARG);
          state_d = S_ECHO;
`endif
        end
      end
      S_ISSUE: begin
        // cmd_in was loaded on entry, so one setup cycle precedes the pulse.
        if (!arm_q) begin
          arm_d = 1'b1;
        end else begin
          act     = 1'b1;
          arm_d   = 1'b0;
          win_d   = START_WIN;
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (bus.nand_busy) begin
          tmr_d   = TIMEOUT_CYC;
          state_d = S_WAIT_DONE;
        end else if (win_q <= 8'd1) begin
          done = 1'b1;
        end else begin
          win_d = win_q - 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.nand_busy) begin
          done = 1'b1;
        end else if (tmr_q <= 24'd1) begin
          // Abort: flag the timeout and end any read loop. nand_master is left running.
          tmo_d   = 1'b1;
          tx_d    = RPL_T;
          cnt_d   = 9'd0;
          state_d = S_SEND;
        end else begin
          tmr_d = tmr_q - 24'd1;
        end
      end
      S_SEND: begin
        if (!bus.reg_dat_wait) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if ((op_q == OP_R) && (cnt_q > 9'd1)) begin
          cnt_d   = cnt_q - 9'd1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ECHO: begin
        if (!bus.reg_dat_wait) state_d = S_ECHO_GAP;
      end
      S_ECHO_GAP: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // An operation completed: reply with the read byte or 'K'.
    if (done) begin
      tx_d    = (op_q == OP_R) ? bus.nand_data_out : RPL_K;
      state_d = S_SEND;
    end

    // A received byte is processed as an opcode or as an argument.
    if (proc_go) begin
      if (!proc_arg) begin
        op_d = proc_byte;
        case (proc_byte)
          OP_C, OP_W, OP_R: state_d = S_GET_ARG;
          OP_S: begin
            tx_d    = {6'b0, tmo_q, bus.nand_busy};
            tmo_d   = 1'b0;
            state_d = S_SEND;
          end
          default: begin
            tx_d    = RPL_Q;
            state_d = S_SEND;
          end
        endcase
      end else begin
        case (op_q)
          OP_C: begin
            cmd_d   = proc_byte;
            arm_d   = 1'b0;
            state_d = S_ISSUE;
          end
          OP_W: begin
            ndata_d = proc_byte;
            tx_d    = RPL_K;
            state_d = S_SEND;
          end
          default: begin
            cnt_d   = (proc_byte == 8'h00) ? 9'd256 : {1'b0, proc_byte};
            cmd_d   = READ_CMD;
            arm_d   = 1'b0;
            state_d = S_ISSUE;
          end
        endcase
      end
    end
  end

  assign bus.reg_dat_re    = re;
  assign bus.reg_dat_we    = (state_q == S_SEND) || (state_q == S_ECHO);
  assign bus.reg_dat_di    = {24'h000000, tx_q};
  assign bus.cmd_in        = cmd_q;
  assign bus.nand_activate = act;
  assign bus.nand_data_in  = ndata_q;
  assign seq_idle          = (state_q == S_IDLE);

endmodule

// File: tb/tb_nand_uart_sequencer.sv
// Directed bench for nand_uart_sequencer (default build, TIMEOUT_CYC = 100).
module tb_nand_uart_sequencer;
  logic hw_clk = 1'b0;
  logic resetn = 1'b0;
  logic seq_idle;

  nand_uart_sequencer_if bus ();

  nand_uart_sequencer #(.TIMEOUT_CYC(24'd100), .START_WIN(8'd8), .READ_CMD(8'h0A)) dut (
    .hw_clk  (hw_clk),
    .resetn  (resetn),
    .bus     (bus.master),
    .seq_idle(seq_idle)
  );

  always #5 hw_clk = ~hw_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       txbusy[$];
  int         txcyc[$];
  logic [7:0] actq[$];
  logic [7:0] dataq[$];
  int act_cnt = 0;
  int act_cyc = 0;
  int setup_err = 0, pulse_err = 0, b2b_err = 0, di_err = 0;
  bit nand_auto = 1'b1;
  int busy_len = 50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge hw_clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic clear_logs();
    txq.delete(); txbusy.delete(); txcyc.delete(); actq.delete();
    act_cnt = 0;
  endtask

  initial forever begin
    @(posedge hw_clk);
    cyc++;
  end

  // UART rx side: a byte is popped on the edge after a sampled re pulse.
  initial begin
    logic re_seen;
    bus.reg_dat_do = 32'hFFFF_FFFF;
    forever begin
      @(negedge hw_clk);
      re_seen = bus.reg_dat_re;
      @(posedge hw_clk);
      #1;
      if (re_seen && rxq.size() > 0) void'(rxq.pop_front());
      bus.reg_dat_do = (rxq.size() > 0) ? {24'h0, rxq[0]} : 32'hFFFF_FFFF;
    end
  end

  // Protocol monitors: tx accepts, activate pulses, and handshake rules.
  initial begin
    logic prev_we = 1'b0, prev_acc = 1'b0, prev_act = 1'b0;
    logic [31:0] prev_di = 32'h0;
    logic [7:0] prev_cmd = 8'h0;
    forever begin
      @(negedge hw_clk);
      if (bus.reg_dat_we && prev_acc) b2b_err++;
      if (bus.reg_dat_we && prev_we && !prev_acc && bus.reg_dat_di != prev_di) di_err++;
      if (bus.reg_dat_we && !bus.reg_dat_wait) begin
        txq.push_back(bus.reg_dat_di[7:0]);
        txbusy.push_back(bus.nand_busy);
        txcyc.push_back(cyc);
      end
      if (bus.nand_activate) begin
        act_cnt++;
        act_cyc = cyc;
        actq.push_back(bus.cmd_in);
        if (bus.cmd_in != prev_cmd) setup_err++;
        if (prev_act) pulse_err++;
      end
      prev_acc = bus.reg_dat_we && !bus.reg_dat_wait;
      prev_we  = bus.reg_dat_we;
      prev_di  = bus.reg_dat_di;
      prev_act = bus.nand_activate;
      prev_cmd = bus.cmd_in;
    end
  end

  // nand_master model: busy rises 3 cycles after activate and stays for busy_len cycles.
  initial begin
    bus.nand_busy = 1'b0;
    bus.nand_data_out = 8'h00;
    forever begin
      @(negedge hw_clk);
      if (bus.nand_activate && nand_auto) begin
        if (dataq.size() > 0) bus.nand_data_out = dataq.pop_front();
        repeat (3) @(negedge hw_clk);
        bus.nand_busy = 1'b1;
        repeat (busy_len) @(negedge hw_clk);
        bus.nand_busy = 1'b0;
      end
    end
  end

  initial begin
    int k;
    bus.reg_dat_wait = 1'b0;
    resetn = 1'b0;
    tick(3);
    chk("rst_re", bus.reg_dat_re, 0);
    chk("rst_we", bus.reg_dat_we, 0);
    chk("rst_act", bus.nand_activate, 0);
    chk("rst_cmd", bus.cmd_in, 0);
    chk("rst_din", bus.nand_data_in, 0);
    chk("rst_di", bus.reg_dat_di, 0);
    chk("rst_idle", seq_idle, 1);
    resetn = 1'b1;
    tick(2);

    // W: load data byte, reply 'K', no activate
    clear_logs();
    rxq.push_back(8'h57); rxq.push_back(8'hA5);
    wait_tx(1, 50);
    chk("w_ntx", txq.size(), 1);
    if (txq.size() > 0) chk("w_reply", txq[0], 8'h4B);
    chk("w_din", bus.nand_data_in, 8'hA5);
    tick(5);
    chk("w_noact", act_cnt, 0);

    // C: single activate, reply 'K' once busy has fallen
    clear_logs();
    busy_len = 50;
    rxq.push_back(8'h43); rxq.push_back(8'h90);
    wait_tx(1, 200);
    chk("c_ntx", txq.size(), 1);
    if (txq.size() > 0) chk("c_reply", txq[0], 8'h4B);
    if (txbusy.size() > 0) chk("c_busy_at_k", txbusy[0], 0);
    chk("c_nact", act_cnt, 1);
    if (actq.size() > 0) chk("c_cmd", actq[0], 8'h90);
    tick(5);

    // R 3: three reads with READ_CMD, bytes returned in order
    clear_logs();
    busy_len = 10;
    dataq.push_back(8'h11); dataq.push_back(8'h22); dataq.push_back(8'h33);
    rxq.push_back(8'h52); rxq.push_back(8'h03);
    wait_tx(3, 300);
    chk("r_ntx", txq.size(), 3);
    if (txq.size() > 2) begin
      chk("r_b0", txq[0], 8'h11);
      chk("r_b1", txq[1], 8'h22);
      chk("r_b2", txq[2], 8'h33);
    end
    tick(30);
    chk("r_nact", act_cnt, 3);
    for (int i = 0; i < actq.size(); i++) chk("r_cmd", actq[i], 8'h0A);
    chk("r_idle", seq_idle, 1);

    // Timeout with busy stuck high; then status twice
    clear_logs();
    nand_auto = 1'b0;
    bus.nand_busy = 1'b1;
    rxq.push_back(8'h43); rxq.push_back(8'h60);
    wait_tx(1, 300);
    chk("t_ntx", txq.size(), 1);
    if (txq.size() > 0) chk("t_reply", txq[0], 8'h54);
    if (txcyc.size() > 0) chk("t_latency", txcyc[0] - act_cyc, 102);
    tick(3);
    clear_logs();
    rxq.push_back(8'h53);
    wait_tx(1, 50);
    chk("s1_ntx", txq.size(), 1);
    if (txq.size() > 0) chk("s1_reply", txq[0], 8'h03);
    tick(3);
    bus.nand_busy = 1'b0;
    clear_logs();
    rxq.push_back(8'h53);
    wait_tx(1, 50);
    if (txq.size() > 0) chk("s2_reply", txq[0], 8'h00);
    else chk("s2_ntx", txq.size(), 1);
    tick(3);

    // Unknown opcode with tx held off for 500 cycles
    clear_logs();
    bus.reg_dat_wait = 1'b1;
    rxq.push_back(8'h58);
    tick(500);
    chk("q_held_ntx", txq.size(), 0);
    chk("q_held_we", bus.reg_dat_we, 1);
    chk("q_held_di", bus.reg_dat_di, 32'h3F);
    bus.reg_dat_wait = 1'b0;
    wait_tx(1, 20);
    tick(20);
    chk("q_ntx", txq.size(), 1);
    if (txq.size() > 0) chk("q_reply", txq[0], 8'h3F);

    // Reset during WAIT_DONE
    clear_logs();
    nand_auto = 1'b1;
    busy_len = 200;
    rxq.push_back(8'h43); rxq.push_back(8'h33);
    k = 0;
    while (!bus.nand_busy && k < 50) begin tick(1); k++; end
    chk("rst_op_busy", bus.nand_busy, 1);
    tick(5);
    resetn = 1'b0;
    tick(1);
    chk("rst_op_act", bus.nand_activate, 0);
    chk("rst_op_we", bus.reg_dat_we, 0);
    chk("rst_op_idle", seq_idle, 1);
    resetn = 1'b1;
    tick(2);
    rxq.push_back(8'h53);
    wait_tx(1, 50);
    if (txq.size() > 0) chk("rst_s_busy", txq[0], 8'h01);
    else chk("rst_s_ntx", txq.size(), 1);
    k = 0;
    while (bus.nand_busy && k < 400) begin tick(1); k++; end
    tick(2);
    clear_logs();
    rxq.push_back(8'h53);
    wait_tx(1, 50);
    if (txq.size() > 0) chk("rst_s_idle", txq[0], 8'h00);
    else chk("rst_s2_ntx", txq.size(), 1);
    tick(5);

    chk("cmd_setup", setup_err, 0);
    chk("act_pulse", pulse_err, 0);
    chk("we_gap", b2b_err, 0);
    chk("di_stable", di_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
